// File: rtl/quench_reset_sequencer.sv
// quench_reset_sequencer
//
// Sequences the quench and recharge drivers of a single-photon avalanche
// detector. An avalanche edge seen while ARMED launches one fixed sequence:
// QUENCH -> DEAD -> RESET -> HOLD (HOLD skipped when its length is zero).
// The sequence then returns to ARMED, or to IDLE if enable has dropped.
// Accepted avalanches are counted in a saturating counter.
//
// Ports
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   enable          arms the detector; sampled only in IDLE/ARMED and at sequence end
//   aval_in         asynchronous avalanche comparator output
//   q_len/r_len/h_len  quench / recharge / hold-off lengths in clk cycles
//   cnt_clr         synchronous photon counter clear
//   quench_en_n     quench driver enable (active-low), low whenever not IDLE
//   quench_pwm      quench drive pulse
//   rst_en, rst_pwm recharge driver enable and drive pulse
//   busy            high during QUENCH/DEAD/RESET/HOLD
//   event_pulse     one-cycle strobe per accepted avalanche
//   photon_cnt      accepted-event count, saturating
//   cnt_sat         sticky, set when photon_cnt reaches all-ones
//   state_dbg       current FSM state encoding, for observation only
//
// Handshake note: there is no valid/ready traffic here; aval_in is a raw
// asynchronous level and event_pulse is a fire-and-forget strobe.

module quench_reset_sequencer #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             aval_in,
  input  logic [LEN_W-1:0] q_len,
  input  logic [LEN_W-1:0] r_len,
  input  logic [LEN_W-1:0] h_len,
  input  logic             cnt_clr,
  output logic             quench_en_n,
  output logic             quench_pwm,
  output logic             rst_en,
  output logic             rst_pwm,
  output logic             busy,
  output logic             event_pulse,
  output logic [CNT_W-1:0] photon_cnt,
  output logic             cnt_sat,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    QUENCH = 3'd2,
    DEAD   = 3'd3,
    RESET  = 3'd4,
    HOLD   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             sync1, sync2, sync3;
  logic             edge_det;
  logic             accept;
  logic [LEN_W-1:0] q_len_l, r_len_l, h_len_l;
  logic [LEN_W-1:0] phase_cnt;
  logic [LEN_W:0]   cnt_inc;
  logic             q_done, r_done, h_done;

  assign state_dbg = state;

  // Two-flop synchronizer plus one extra stage for rising-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= aval_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign edge_det = sync2 & ~sync3;
  // A disarm request in ARMED wins over a coincident edge.
  assign accept   = (state == ARMED) && enable && edge_det;

  // phase_cnt counts up from 0 in each timed phase; a phase of length L
  // ends when phase_cnt+1 >= L, so L=0 behaves as L=1 where that applies.
  assign cnt_inc = {1'b0, phase_cnt} + {{LEN_W{1'b0}}, 1'b1};
  assign q_done  = cnt_inc >= {1'b0, q_len_l};
  assign r_done  = cnt_inc >= {1'b0, r_len_l};
  assign h_done  = cnt_inc >= {1'b0, h_len_l};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      q_len_l     <= '0;
      r_len_l     <= '0;
      h_len_l     <= '0;
      phase_cnt   <= '0;
      quench_en_n <= 1'b1;
      quench_pwm  <= 1'b0;
      rst_en      <= 1'b0;
      rst_pwm     <= 1'b0;
      busy        <= 1'b0;
      event_pulse <= 1'b0;
    end else begin
      event_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state       <= ARMED;
            quench_en_n <= 1'b0;
          end
        end
        ARMED: begin
          if (!enable) begin
            state       <= IDLE;
            quench_en_n <= 1'b1;
          end else if (edge_det) begin
            state       <= QUENCH;
            q_len_l     <= q_len;
            r_len_l     <= r_len;
            h_len_l     <= h_len;
            phase_cnt   <= '0;
            quench_pwm  <= 1'b1;
            busy        <= 1'b1;
            event_pulse <= 1'b1;
          end
        end
        QUENCH: begin
          if (q_done) begin
            state      <= DEAD;
            quench_pwm <= 1'b0;
            rst_en     <= 1'b1;
          end else begin
            phase_cnt <= cnt_inc[LEN_W-1:0];
          end
        end
        DEAD: begin
          // Single gap cycle keeps the two drive pulses non-adjacent.
          state     <= RESET;
          rst_pwm   <= 1'b1;
          phase_cnt <= '0;
        end
        RESET: begin
          if (r_done) begin
            rst_pwm   <= 1'b0;
            rst_en    <= 1'b0;
            phase_cnt <= '0;
            if (h_len_l == '0) begin
              state       <= enable ? ARMED : IDLE;
              busy        <= 1'b0;
              quench_en_n <= ~enable;
            end else begin
              state <= HOLD;
            end
          end else begin
            phase_cnt <= cnt_inc[LEN_W-1:0];
          end
        end
        HOLD: begin
          if (h_done) begin
            state       <= enable ? ARMED : IDLE;
            busy        <= 1'b0;
            quench_en_n <= ~enable;
          end else begin
            phase_cnt <= cnt_inc[LEN_W-1:0];
          end
        end
        default: begin
          state       <= IDLE;
          quench_en_n <= 1'b1;
          quench_pwm  <= 1'b0;
          rst_en      <= 1'b0;
          rst_pwm     <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  // Saturating photon counter; a clear coinciding with an event leaves 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      photon_cnt <= '0;
      cnt_sat    <= 1'b0;
    end else if (cnt_clr) begin
      photon_cnt <= accept ? CNT_ONE : '0;
      cnt_sat    <= 1'b0;
    end else if (accept && (photon_cnt != CNT_MAX)) begin
      photon_cnt <= photon_cnt + CNT_ONE;
      if (photon_cnt == (CNT_MAX - CNT_ONE)) cnt_sat <= 1'b1;
    end
  end

endmodule

// File: tb/tb_quench_reset_sequencer.sv
// Testbench for quench_reset_sequencer (LEN_W=8, CNT_W=4).
// Directed table, hand-written corner sequences, then random stimulus,
// all checked against a timestamp-based reference model.

module tb_quench_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, aval_in, cnt_clr;
  logic [7:0] q_len, r_len, h_len;
  logic       quench_en_n, quench_pwm, rst_en, rst_pwm, busy, event_pulse;
  logic [3:0] photon_cnt;
  logic       cnt_sat;
  logic [2:0] state_dbg;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  quench_reset_sequencer #(.LEN_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .aval_in(aval_in),
    .q_len(q_len), .r_len(r_len), .h_len(h_len), .cnt_clr(cnt_clr),
    .quench_en_n(quench_en_n), .quench_pwm(quench_pwm), .rst_en(rst_en),
    .rst_pwm(rst_pwm), .busy(busy), .event_pulse(event_pulse),
    .photon_cnt(photon_cnt), .cnt_sat(cnt_sat), .state_dbg(state_dbg)
  );

  // ---------------- reference model ----------------
  // A sequence is described by its start edge t0 and lengths; output
  // windows follow from arithmetic on the edge index.
  int  cyc;
  bit  av_log[$];
  bit  m_armed, m_seq;
  int  t0, qn, rn, hn;
  int  m_cnt;
  bit  m_sat;
  bit  e_q, e_ren, e_rpwm, e_busy, e_ev, e_qen_n;
  bit  prev_q, prev_r;
  int  q_hi, r_hi, busy_hi, ev_hi;

  task automatic model_reset();
    cyc = 0;
    av_log.delete();
    for (int i = 0; i < 3; i++) av_log.push_back(1'b0);
    m_armed = 0; m_seq = 0; t0 = 0; qn = 1; rn = 1; hn = 0;
    m_cnt = 0; m_sat = 0;
    e_q = 0; e_ren = 0; e_rpwm = 0; e_busy = 0; e_ev = 0; e_qen_n = 1;
    prev_q = 0; prev_r = 0;
  endtask

  task automatic model_step(input bit en, input bit av, input bit clr,
                            input int q, input int r, input int h);
    int n;
    bit det, acc;
    cyc++;
    av_log.push_back(av);
    if (av_log.size() > 8) void'(av_log.pop_front());
    n   = av_log.size();
    det = av_log[n-3] && !av_log[n-4];
    acc = 0;
    if (m_seq) begin
      if (cyc == t0 + qn + rn + hn + 1) begin
        m_seq   = 0;
        m_armed = en;
      end
    end else if (m_armed) begin
      if (!en) m_armed = 0;
      else if (det) begin
        m_seq = 1; t0 = cyc;
        qn = (q < 1) ? 1 : q;
        rn = (r < 1) ? 1 : r;
        hn = h;
        acc = 1;
      end
    end else if (en) begin
      m_armed = 1;
    end
    if (acc && clr) begin m_cnt = 1; m_sat = 0; end
    else if (clr) begin m_cnt = 0; m_sat = 0; end
    else if (acc && m_cnt < 15) begin
      m_cnt++;
      if (m_cnt == 15) m_sat = 1;
    end
    e_q     = m_seq && cyc >= t0 && cyc < t0 + qn;
    e_ren   = m_seq && cyc >= t0 + qn && cyc <= t0 + qn + rn;
    e_rpwm  = m_seq && cyc > t0 + qn && cyc <= t0 + qn + rn;
    e_busy  = m_seq;
    e_qen_n = !(m_seq || m_armed);
    e_ev    = acc;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input bit en, input bit av, input bit clr,
                      input int q, input int r, input int h);
    enable = en; aval_in = av; cnt_clr = clr;
    q_len = 8'(q); r_len = 8'(r); h_len = 8'(h);
    @(posedge clk);
    model_step(en, av, clr, q, r, h);
    #1;
    chk("quench_en_n", quench_en_n, e_qen_n);
    chk("quench_pwm", quench_pwm, e_q);
    chk("rst_en", rst_en, e_ren);
    chk("rst_pwm", rst_pwm, e_rpwm);
    chk("busy", busy, e_busy);
    chk("event_pulse", event_pulse, e_ev);
    chk("photon_cnt", photon_cnt, m_cnt);
    chk("cnt_sat", cnt_sat, m_sat);
    chk("pwm_overlap_or_adjacent",
        (quench_pwm && (rst_pwm || prev_r)) || (rst_pwm && prev_q), 0);
    prev_q = quench_pwm; prev_r = rst_pwm;
    q_hi    += int'(quench_pwm);
    r_hi    += int'(rst_pwm);
    busy_hi += int'(busy);
    ev_hi   += int'(event_pulse);
  endtask

  task automatic seq(input int n, input logic [63:0] av_m, input logic [63:0] en_m,
                     input logic [63:0] clr_m, input int q, input int r, input int h);
    for (int i = 0; i < n; i++) step(en_m[i], av_m[i], clr_m[i], q, r, h);
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable = 0; aval_in = 0; cnt_clr = 0;
    q_len = 0; r_len = 0; h_len = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_quench_en_n"}, quench_en_n, 1);
    chk({tag, "_quench_pwm"}, quench_pwm, 0);
    chk({tag, "_rst_en"}, rst_en, 0);
    chk({tag, "_rst_pwm"}, rst_pwm, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_event_pulse"}, event_pulse, 0);
    chk({tag, "_photon_cnt"}, photon_cnt, 0);
    chk({tag, "_cnt_sat"}, cnt_sat, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit en, av;
    int q, r, h;
    bit qpwm, ren, rpwm, bsy, ev, qen_n;
    int cnt;
  } vec_t;

  vec_t tv[14];

  initial begin
    int cnt_before;

    // Single pulse, q=4 r=3 h=2; lengths change mid-sequence to 9 and must be ignored.
    tv[0]  = '{1,0,4,3,2, 0,0,0,0,0,0, 0};
    tv[1]  = '{1,1,4,3,2, 0,0,0,0,0,0, 0};
    tv[2]  = '{1,0,4,3,2, 0,0,0,0,0,0, 0};
    tv[3]  = '{1,0,4,3,2, 1,0,0,1,1,0, 1};
    tv[4]  = '{1,0,9,9,9, 1,0,0,1,0,0, 1};
    tv[5]  = '{1,0,9,9,9, 1,0,0,1,0,0, 1};
    tv[6]  = '{1,0,9,9,9, 1,0,0,1,0,0, 1};
    tv[7]  = '{1,0,9,9,9, 0,1,0,1,0,0, 1};
    tv[8]  = '{1,0,9,9,9, 0,1,1,1,0,0, 1};
    tv[9]  = '{1,0,9,9,9, 0,1,1,1,0,0, 1};
    tv[10] = '{1,0,9,9,9, 0,1,1,1,0,0, 1};
    tv[11] = '{1,0,9,9,9, 0,0,0,1,0,0, 1};
    tv[12] = '{1,0,9,9,9, 0,0,0,1,0,0, 1};
    tv[13] = '{1,0,9,9,9, 0,0,0,0,0,0, 1};

    q_hi = 0; r_hi = 0; busy_hi = 0; ev_hi = 0;
    rst = 1'b1; enable = 0; aval_in = 0; cnt_clr = 0;
    q_len = 0; r_len = 0; h_len = 0;
    #2;
    chk_reset_outputs("in_reset");
    apply_reset();
    chk_reset_outputs("after_reset");

    for (int i = 0; i < 14; i++) begin
      step(tv[i].en, tv[i].av, 0, tv[i].q, tv[i].r, tv[i].h);
      chk($sformatf("tv%0d_quench_pwm", i), quench_pwm, tv[i].qpwm);
      chk($sformatf("tv%0d_rst_en", i), rst_en, tv[i].ren);
      chk($sformatf("tv%0d_rst_pwm", i), rst_pwm, tv[i].rpwm);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].bsy);
      chk($sformatf("tv%0d_event_pulse", i), event_pulse, tv[i].ev);
      chk($sformatf("tv%0d_quench_en_n", i), quench_en_n, tv[i].qen_n);
      chk($sformatf("tv%0d_photon_cnt", i), photon_cnt, tv[i].cnt);
    end

    // Extra edges during QUENCH, during HOLD and on the final HOLD cycle: ignored.
    step(1, 0, 1, 4, 3, 2);
    ev_hi = 0;
    seq(16, 64'h509, '1, '0, 4, 3, 2);
    chk("retrigger_cnt", photon_cnt, 1);
    chk("retrigger_events", ev_hi, 1);

    // All-zero lengths: 1 quench, 1 dead, 1 reset cycle, straight back to ARMED.
    q_hi = 0; r_hi = 0; busy_hi = 0;
    seq(10, 64'h1, '1, '0, 0, 0, 0);
    chk("zero_len_quench_cycles", q_hi, 1);
    chk("zero_len_reset_cycles", r_hi, 1);
    chk("zero_len_busy_cycles", busy_hi, 3);
    chk("zero_len_armed", quench_en_n, 0);

    // Enable drops during RESET: sequence completes, then IDLE; later edges ignored.
    cnt_before = int'(photon_cnt);
    seq(16, 64'h2401, 64'h3F, '0, 2, 3, 1);
    chk("disable_idle_qen_n", quench_en_n, 1);
    chk("disable_cnt", photon_cnt, cnt_before + 1);

    // Saturation with 17 spaced events, then clear coinciding with an event.
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) seq(7, 64'h1, '1, '0, 0, 0, 0);
    chk("sat_cnt", photon_cnt, 15);
    chk("sat_flag", cnt_sat, 1);
    seq(7, 64'h1, '1, 64'h4, 0, 0, 0);
    chk("clr_event_cnt", photon_cnt, 1);
    chk("clr_event_sat", cnt_sat, 0);

    // Asynchronous reset while quench_pwm is high.
    seq(4, 64'h1, '1, '0, 4, 3, 2);
    chk("pre_rst_quench_pwm", quench_pwm, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seq(3, '0, '0, '0, 4, 3, 2);
    chk("post_rst_idle", quench_en_n, 1);

    // Randomized stimulus against the model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 40) == 0,
           $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
